// File: rtl/div_sqrt_preproc_par.sv
// Operand pre-processing for a parallel divide / square-root unit: classifies and normalizes
// IEEE operands behind a one-deep valid/ready register slice. Define DIV_SQRT_PREPROC_FTZ_EN to flush subnormals.
module div_sqrt_preproc_par #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 23,
    parameter int unsigned RM_W   = 3
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    input  logic                      In_valid_SI,
    output logic                      In_ready_SO,
    input  logic                      Op_SI,
    input  logic [1+EXP_W+MANT_W-1:0] Operand_a_DI,
    input  logic [1+EXP_W+MANT_W-1:0] Operand_b_DI,
    input  logic [RM_W-1:0]           RM_SI,
    input  logic                      Kill_SI,
    output logic                      Out_valid_SO,
    input  logic                      Out_ready_SI,
    output logic                      Op_SO,
    output logic [RM_W-1:0]           RM_SO,
    output logic                      Sign_z_DO,
    output logic [EXP_W+1:0]          Exp_a_DO,
    output logic [EXP_W+1:0]          Exp_b_DO,
    output logic [MANT_W:0]           Mant_a_DO,
    output logic [MANT_W:0]           Mant_b_DO,
    output logic [4:0]                Class_a_DO,
    output logic [4:0]                Class_b_DO
);

    localparam int unsigned OP_W = 1 + EXP_W + MANT_W;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned MW   = MANT_W + 1;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

`ifndef DIV_SQRT_PREPROC_FTZ_EN
    localparam int unsigned LZ_W = $clog2(MW + 1);

    // Leading-zero count over the MW-bit subnormal significand.
    function automatic logic [LZ_W-1:0] lead_zeros(input logic [MW-1:0] m);
        logic found;
        lead_zeros = '0;
        found      = 1'b0;
        for (int i = int'(MW) - 1; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      lead_zeros = lead_zeros + LZ_W'(1);
            end
        end
    endfunction
`endif

    // Class bits {sNaN, qNaN, Inf, Subnormal, Zero}.
    function automatic logic [4:0] classify(input logic [OP_W-1:0] op);
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] f;
        logic              e_zero, e_ones, f_zero;
        e      = op[OP_W-2 -: EXP_W];
        f      = op[MANT_W-1:0];
        e_zero = (e == '0);
        e_ones = (e == '1);
        f_zero = (f == '0);
        classify    = '0;
`ifdef DIV_SQRT_PREPROC_FTZ_EN
        classify[0] = e_zero;
`else
        classify[0] = e_zero & f_zero;
`endif
        classify[1] = e_zero & ~f_zero;
        classify[2] = e_ones & f_zero;
        classify[3] = e_ones & f[MANT_W-1];
        classify[4] = e_ones & ~f_zero & ~f[MANT_W-1];
    endfunction

    // Returns {exponent, mantissa-with-hidden-bit}.
    function automatic logic [EW+MW-1:0] normalize(input logic [OP_W-1:0] op);
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] f;
        logic [EW-1:0]     exp_n;
        logic [MW-1:0]     mant_n;
`ifndef DIV_SQRT_PREPROC_FTZ_EN
        logic [LZ_W-1:0]   lz;
`endif
        e      = op[OP_W-2 -: EXP_W];
        f      = op[MANT_W-1:0];
        exp_n  = '0;
        mant_n = '0;
        if (e == '1) begin
            exp_n  = {2'b00, e};
            mant_n = {1'b0, f};
        end else if (e == '0) begin
            if (f != '0) begin
`ifdef DIV_SQRT_PREPROC_FTZ_EN
                exp_n  = '0;
                mant_n = '0;
`else
                lz     = lead_zeros({1'b0, f});
                mant_n = {1'b0, f} << lz;
                exp_n  = EW'(1) - EW'(lz);
`endif
            end
        end else begin
            exp_n  = {2'b00, e};
            mant_n = {1'b1, f};
        end
        normalize = {exp_n, mant_n};
    endfunction

    logic [0:0]       state_q, state_d;
    logic             accept_c;
    logic [EW+MW-1:0] norm_a_c, norm_b_c;
    logic [4:0]       class_a_c, class_b_c;
    logic             sign_z_c;

    assign In_ready_SO  = ~Kill_SI & (~Out_valid_SO | Out_ready_SI);
    assign accept_c     = In_valid_SI & In_ready_SO;
    assign Out_valid_SO = (state_q == FULL);

    // Operand datapath; operand b is forced to zero for sqrt.
    always_comb begin
        norm_a_c  = normalize(Operand_a_DI);
        class_a_c = classify(Operand_a_DI);
        norm_b_c  = '0;
        class_b_c = '0;
        sign_z_c  = Operand_a_DI[OP_W-1];
        if (!Op_SI) begin
            norm_b_c  = normalize(Operand_b_DI);
            class_b_c = classify(Operand_b_DI);
            sign_z_c  = Operand_a_DI[OP_W-1] ^ Operand_b_DI[OP_W-1];
        end
    end

    // Slice occupancy: kill dominates, accept refills, drain empties.
    always_comb begin
        state_d = state_q;
        if (Kill_SI)                  state_d = EMPTY;
        else if (accept_c)            state_d = FULL;
        else if (Out_ready_SI)        state_d = EMPTY;
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            Op_SO      <= 1'b0;
            RM_SO      <= '0;
            Sign_z_DO  <= 1'b0;
            Exp_a_DO   <= '0;
            Mant_a_DO  <= '0;
            Class_a_DO <= '0;
            Exp_b_DO   <= '0;
            Mant_b_DO  <= '0;
            Class_b_DO <= '0;
        end else if (accept_c) begin
            Op_SO      <= Op_SI;
            RM_SO      <= RM_SI;
            Sign_z_DO  <= sign_z_c;
            Exp_a_DO   <= norm_a_c[EW+MW-1:MW];
            Mant_a_DO  <= norm_a_c[MW-1:0];
            Class_a_DO <= class_a_c;
            Exp_b_DO   <= norm_b_c[EW+MW-1:MW];
            Mant_b_DO  <= norm_b_c[MW-1:0];
            Class_b_DO <= class_b_c;
        end
    end

endmodule

// File: doc/div_sqrt_preproc_par.md
DIV_SQRT_PREPROC_PAR -- requirements
Module: div_sqrt_preproc_par

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (legal range >=2).
REQ-002 SHALL have parameter MANT_W, default 23, stored fraction width (legal range >=2).
REQ-003 SHALL have parameter RM_W, default 3, rounding-mode width.
REQ-004 Ports (OP_W = 1+EXP_W+MANT_W):
- Clk_CI  in  1  clock; one clock, all state on rising edge.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- In_valid_SI  in  1  operands valid.
- In_ready_SO  out  1  block can accept.
- Op_SI  in  1  0=div, 1=sqrt.
- Operand_a_DI  in  OP_W  IEEE operand a (dividend/radicand).
- Operand_b_DI  in  OP_W  IEEE operand b (divisor; ignored for sqrt).
- RM_SI  in  RM_W  rounding mode.
- Kill_SI  in  1  flush.
- Out_valid_SO  out  1  result valid.
- Out_ready_SI  in  1  consumer accepts.
- Op_SO  out  1  registered Op_SI.
- RM_SO  out  RM_W  registered RM_SI.
- Sign_z_DO  out  1  result sign.
- Exp_a_DO, Exp_b_DO  out  EXP_W+2  normalized exponent, two's complement.
- Mant_a_DO, Mant_b_DO  out  MANT_W+1  normalized mantissa incl. hidden bit.
- Class_a_DO, Class_b_DO  out  5  {sNaN, qNaN, Inf, Subnormal, Zero}.

Function
REQ-005 SHALL accept a transaction when In_valid_SI=1 and In_ready_SO=1 in the same cycle.
REQ-006 SHALL drive In_ready_SO = ~Kill_SI & (~Out_valid_SO | Out_ready_SI), combinational.
REQ-007 SHALL implement two-state FSM EMPTY/FULL; EMPTY->FULL on accept; FULL->EMPTY on Out_ready_SI & no accept; FULL->FULL on accept with simultaneous drain (throughput 1/cycle); any state->EMPTY on Kill_SI.
REQ-008 SHALL present results one cycle after accept; Out_valid_SO=1 exactly in FULL.
REQ-009 SHALL hold all outputs stable while Out_valid_SO=1 and Out_ready_SI=0.
REQ-010 Classification per operand: Zero = exp==0 & frac==0; Subnormal = exp==0 & frac!=0; Inf = exp==all-ones & frac==0; qNaN = exp==all-ones & frac[MANT_W-1]=1; sNaN = exp==all-ones & frac!=0 & frac[MANT_W-1]=0; one-hot or all-zero.
REQ-011 Normal operand: Mant = {1,frac}, Exp = zero-extended exp field.
REQ-012 Subnormal operand: lz = leading zeros of {0,frac} over MANT_W+1 bits; Mant = {0,frac}<<lz; Exp = 1-lz (negative allowed).
REQ-013 Zero operand: Mant=0, Exp=0; Inf/NaN: Mant={0,frac}, Exp = all-ones field zero-extended.
REQ-014 Div: Sign_z_DO = sign_a ^ sign_b; sqrt: Sign_z_DO = sign_a.
REQ-015 Sqrt: Exp_b_DO, Mant_b_DO, Class_b_DO SHALL be 0 regardless of Operand_b_DI.
REQ-016 Kill_SI=1 SHALL block capture that cycle and force Out_valid_SO=0 the next cycle; data regs need not clear.
REQ-017 Data registers SHALL load only on accept.

Reset
REQ-018 Rst_RBI=0 SHALL asynchronously force FSM=EMPTY and all registered outputs (Out_valid_SO, Op_SO, RM_SO, Sign_z_DO, Exp_*, Mant_*, Class_*) to 0.
REQ-019 Reset mid-transaction SHALL discard the pending result; first accept after deassertion behaves as from EMPTY.

Configuration
REQ-020 Macro DIV_SQRT_PREPROC_FTZ_EN defined: subnormal operands SHALL output Mant=0, Exp=0, Class = Zero|Subnormal bits set; LZ counter/shifter omitted.
REQ-021 Macro undefined: subnormals SHALL be normalized per REQ-012, Class = Subnormal only.

Verification (EXP_W=8, MANT_W=23)
REQ-022 Div a=0x40400000, b=0xC0000000, accept cycle N -> cycle N+1: Out_valid=1, Exp_a=128, Mant_a=0xC00000, Exp_b=128, Mant_b=0x800000, Sign_z=1, Class=0.
REQ-023 Sqrt a=0x00000001 -> Mant_a=0x800000, Exp_a=-22 (0x3EA), Class_a=00010, b outputs 0; with FTZ_EN: Mant_a=0, Exp_a=0, Class_a=00011.
REQ-024 Div a=0x7F800001, b=0x7FC00000 -> Class_a=10000, Class_b=01000; a=0x7F800000, b=0x80000000 -> Class_a=00100, Class_b=00001, Sign_z=1.
REQ-025 FULL, Out_ready=0 for 2 cycles with In_valid=1 -> In_ready=0, outputs unchanged; Out_ready=1 -> drain and new accept same cycle, new result next cycle.
REQ-026 FULL, Kill=1 one cycle -> In_ready=0 that cycle, Out_valid=0 next; Rst_RBI=0 while FULL -> all outputs 0 immediately, without clock edge.
